// File: rtl/toaster_pkg.sv
// Shared key codes, entry FSM states and the seconds width used by the
// keypad entry block and the countdown/PWM timer.
package toaster_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam int         TIME_W    = 10;

  typedef enum logic {ENTRY, WRITE} entry_state_t;

endpackage

// File: rtl/keypad_time_entry_bcd_to_seconds.sv
// Combinational {M, S_tens, S_ones} BCD to whole seconds.
// Seconds fields above 59 are legal and simply add up (1:75 -> 135).
module bcd_to_seconds
  import toaster_pkg::*;
#(
  parameter int W = TIME_W
) (
  input  logic [11:0]  bcd,
  output logic [W-1:0] seconds
);

  logic [W-1:0] mins, tens, ones;

  always_comb begin
    mins    = W'(bcd[11:8]);
    tens    = W'(bcd[7:4]);
    ones    = W'(bcd[3:0]);
    seconds = mins * W'(60) + tens * W'(10) + ones;
  end

endmodule

// File: rtl/keypad_time_entry.sv
// Collects keypad digits into an M:SS buffer and, on ENTER, loads the timer
// through a write/write_ack handshake with an ack timeout.
module keypad_time_entry
  import toaster_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int TW          = TIME_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  input  logic          write_ack,
  output logic [TW-1:0] Time,
  output logic          write,
  output logic [11:0]   entry_LED,
  output logic [1:0]    digit_cnt,
  output logic          busy,
  output logic          ack_err
);

  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(ACK_TIMEOUT - 1);

  entry_state_t  state_q, state_d;
  logic [TW-1:0] time_q, time_d;
  logic          write_q, write_d;
  logic [11:0]   entry_q, entry_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [TW-1:0] entry_seconds;

  bcd_to_seconds #(.W(TW)) u_conv (
    .bcd     (entry_q),
    .seconds (entry_seconds)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    write_d = write_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    err_d   = err_q;
    wait_d  = wait_q;
    case (state_q)
      ENTRY: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            entry_d = {entry_q[7:0], key_code};
            cnt_d   = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
            err_d   = 1'b0;
          end else if (key_code == KEY_CLEAR) begin
            entry_d = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else if (key_code == KEY_ENTER) begin
            time_d  = entry_seconds;
            write_d = 1'b1;
            busy_d  = 1'b1;
            wait_d  = '0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (write_ack) begin
          write_d = 1'b0;
          busy_d  = 1'b0;
          entry_d = '0;
          cnt_d   = '0;
          state_d = ENTRY;
        end else if (wait_q == WAIT_LAST) begin
          // Abandon the load but keep the buffer so ENTER can be retried.
          write_d = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ENTRY;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
      time_q  <= '0;
      write_q <= 1'b0;
      entry_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      write_q <= write_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  assign Time      = time_q;
  assign write     = write_q;
  assign entry_LED = entry_q;
  assign digit_cnt = cnt_q;
  assign busy      = busy_q;
  assign ack_err   = err_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry: a decimal-number model checked on
// every cycle plus literal expectations from the test plan.
module tb_keypad_time_entry;

  localparam int ACK_TIMEOUT = 16;
  localparam int TW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'd0;
  logic          write_ack = 1'b0;
  logic          ack_en = 1'b1;
  logic [TW-1:0] Time;
  logic          write;
  logic [11:0]   entry_LED;
  logic [1:0]    digit_cnt;
  logic          busy;
  logic          ack_err;

  int checks = 0;
  int errors = 0;

  keypad_time_entry #(.ACK_TIMEOUT(ACK_TIMEOUT), .TW(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .write_ack (write_ack),
    .Time      (Time),
    .write     (write),
    .entry_LED (entry_LED),
    .digit_cnt (digit_cnt),
    .busy      (busy),
    .ack_err   (ack_err)
  );

  always #5 clk = ~clk;

  // Timer stand-in: registered ack, one cycle after it sees write.
  always @(posedge clk) write_ack <= ack_en & write;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: the buffer is a decimal number 0..999 (last three digits typed).
  int m_entry = 0, m_cnt = 0, m_time = 0, m_wcyc = 0;
  bit m_write = 0, m_err = 0, started = 0;

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      m_entry = 0; m_cnt = 0; m_time = 0; m_wcyc = 0; m_write = 0; m_err = 0;
    end else if (m_write) begin
      if (write_ack) begin
        m_write = 0; m_entry = 0; m_cnt = 0;
      end else if (m_wcyc == ACK_TIMEOUT) begin
        m_write = 0; m_err = 1;
      end else begin
        m_wcyc++;
      end
    end else if (key_valid) begin
      if (key_code < 4'd10) begin
        m_entry = (m_entry * 10 + int'(key_code)) % 1000;
        m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
        m_err = 0;
      end else if (key_code == 4'hA) begin
        m_time = (m_entry / 100) * 60 + (m_entry % 100);
        m_write = 1; m_wcyc = 1;
      end else if (key_code == 4'hB) begin
        m_entry = 0; m_cnt = 0; m_err = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_write", int'(write), int'(m_write));
      chk("model_busy", int'(busy), int'(m_write));
      chk("model_time", int'(Time), m_time);
      chk("model_led", int'(entry_LED),
          ((m_entry / 100) << 8) | (((m_entry / 10) % 10) << 4) | (m_entry % 10));
      chk("model_cnt", int'(digit_cnt), m_cnt);
      chk("model_err", int'(ack_err), int'(m_err));
    end
  end

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Called at the negedge right after ENTER; returns cycles write stayed high.
  task automatic write_width(output int n);
    n = 0;
    while (write === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("write_bound", n, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_write", int'(write), 0);
    chk("reset_led", int'(entry_LED), 0);
    chk("reset_time", int'(Time), 0);
    reset = 1'b0;

    // 1: 1,3,0 ENTER -> 90 seconds, two-cycle handshake
    press(4'd1); press(4'd3); press(4'd0);
    chk("t1_led", int'(entry_LED), 'h130);
    press(4'hA);
    chk("t1_time", int'(Time), 90);
    write_width(n);
    chk("t1_width", n, 2);
    chk("t1_cnt", int'(digit_cnt), 0);
    chk("t1_led_after", int'(entry_LED), 0);

    // 2: four digits, oldest dropped
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("t2_led", int'(entry_LED), 'h234);
    chk("t2_cnt", int'(digit_cnt), 3);
    press(4'hA);
    chk("t2_time", int'(Time), 154);
    write_width(n);

    // 3: maximum entry
    press(4'd9); press(4'd9); press(4'd9);
    press(4'hA);
    chk("t3_time", int'(Time), 639);
    write_width(n);

    // 4: empty ENTER cancels; 5,CLEAR,ENTER also gives 0
    press(4'hA);
    chk("t4_time0", int'(Time), 0);
    chk("t4_write", int'(write), 1);
    write_width(n);
    press(4'd5); press(4'hB);
    chk("t4_clear_led", int'(entry_LED), 0);
    press(4'hA);
    chk("t4_time1", int'(Time), 0);
    write_width(n);
    press(4'hE);
    chk("t4_ignored", int'(entry_LED), 0);

    // 5: timeout, retry, ack_err cleared by next digit
    ack_en = 1'b0;
    press(4'd4); press(4'd5);
    press(4'hA);
    write_width(n);
    chk("t5_width", n, ACK_TIMEOUT);
    chk("t5_err", int'(ack_err), 1);
    chk("t5_led", int'(entry_LED), 'h045);
    ack_en = 1'b1;
    press(4'hA);
    chk("t5_time", int'(Time), 45);
    write_width(n);
    chk("t5_err_kept", int'(ack_err), 1);
    press(4'd7);
    chk("t5_err_clr", int'(ack_err), 0);
    press(4'hB);

    // 6: key during WRITE ignored; reset mid-WRITE
    press(4'd2); press(4'd0);
    press(4'hA);
    key_valid = 1'b1; key_code = 4'd8;
    @(negedge clk);
    key_valid = 1'b0;
    write_width(n);
    chk("t6_time", int'(Time), 20);
    chk("t6_led", int'(entry_LED), 0);
    ack_en = 1'b0;
    press(4'd2); press(4'd0);
    press(4'hA);
    repeat (3) @(negedge clk);
    chk("t6_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_write", int'(write), 0);
    chk("t6_rst_led", int'(entry_LED), 0);
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
